// File: rtl/mult_pkg.sv
// Shared types and default sizing for the sequential shift-and-add multiplier.
// No latency and no handshake: types, constants and helper functions only.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MULT_W = 4;
  localparam int PROD_W = 2 * MULT_W;
  localparam int CNT_W  = $clog2(MULT_W + 1);

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_1bit.sv
// Single full adder cell, the ripple-chain building block.
// Purely combinational with zero latency; it has no handshake and no backpressure.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple-carry adder made of adder_1bit cells; carry-in is tied to zero.
// Purely combinational with zero latency; it has no handshake and no backpressure.
module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    adder_1bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .s   (r[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one partial-product add per clock.
// Latency is WIDTH+1 edges from acceptance to out_valid (1 edge for zero operands under SEQ_MULT_ZERO_SKIP_EN).
// Backpressure: the product is held in DONE until out_ready, and in_ready is high only in IDLE.
module seq_mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] add_r;
  logic             add_cout;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_shift;
  logic             zero_op;
  logic             last_step;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_step = (count == CW'(WIDTH - 1));

  adder_nbit #(.WIDTH(WIDTH)) u_add (
    .a   (acc[PW-1:WIDTH]),
    .b   (mcand),
    .r   (add_r),
    .cout(add_cout)
  );

  // The carry-out lands in the top bit of the shifted accumulator, so nothing is lost.
  assign sum       = acc[0] ? {add_cout, add_r} : {1'b0, acc[PW-1:WIDTH]};
  assign acc_shift = {sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = zero_op ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            count <= '0;
            if (zero_op) product <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_shift;
          count <= count + CW'(1);
          if (last_step) product <= acc_shift;
        end
        default: ;
      endcase
    end
  end

endmodule
